gmem_fill_engine: RTL and testbench

Bus-mapped drawing engine in the `sys_clk_i` domain that generates all write traffic into the graphics memory (gmem) port A, ahead of the HDMI scan-out path. It accepts single-pixel writes and hardware rectangle fills from the CPU register bus. It emits at most one RGB565 write per cycle on the gmem enable, write-enable, address and data lines.

---
 rtl/gmem_pkg.sv | 30 +++
 rtl/gmem_fill_engine_walker.sv | 76 +++++++
 rtl/gmem_fill_engine.sv | 170 +++++++++++++++++
 tb/tb_gmem_fill_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmem_pkg.sv
// Shared definitions for the gmem fill engine: register map, CTRL/STATUS bit
// positions, pixel type, FSM states and the linear address helper.
package gmem_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_RECT_POS  = 3'd2;
    localparam logic [2:0] REG_RECT_SIZE = 3'd3;
    localparam logic [2:0] REG_COLOR     = 3'd4;
    localparam logic [2:0] REG_PIXEL     = 3'd5;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // y*pitch + x, wrapped to the 15-bit gmem word address space
    function automatic logic [14:0] lin_addr(input logic [8:0] y, input logic [8:0] x,
                                             input int unsigned pitch);
        return 15'(32'(y) * pitch + 32'(x));
    endfunction

endpackage

// File: rtl/gmem_fill_engine_walker.sv
// Raster walker: x/y/row_base counters with a last-pixel flag; presents the
// next pixel to emit. Bounds check built only with GMEM_FILL_CLIP_EN.
module gmem_raster_walker
    import gmem_pkg::*;
#(
    parameter int unsigned FB_W = 160,
    parameter int unsigned FB_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  x0,
    input  logic [7:0]  y0,
    input  logic [7:0]  w,
    input  logic [7:0]  h,
    output logic [14:0] nxt_addr,
    output logic        nxt_in_bounds,
    output logic        last
);

    logic [8:0]  cur_x, cur_y, x_start, x_end, y_end;
    logic [8:0]  nxt_x, nxt_y;
    logic [14:0] row_base, nxt_row;

    assign last = (cur_x + 9'd1 == x_end) && (cur_y + 9'd1 == y_end);

    // Only the load uses a multiply; stepping adds FB_W per row.
    always_comb begin
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        nxt_row = row_base;
        if (load) begin
            nxt_x   = {1'b0, x0};
            nxt_y   = {1'b0, y0};
            nxt_row = lin_addr({1'b0, y0}, 9'd0, FB_W);
        end else if (step) begin
            if (cur_x + 9'd1 == x_end) begin
                nxt_x   = x_start;
                nxt_y   = cur_y + 9'd1;
                nxt_row = row_base + 15'(FB_W);
            end else begin
                nxt_x = cur_x + 9'd1;
            end
        end
    end

    assign nxt_addr = nxt_row + {6'b0, nxt_x};

`ifdef GMEM_FILL_CLIP_EN
    assign nxt_in_bounds = (32'(nxt_x) < FB_W) && (32'(nxt_y) < FB_H);
`else
    assign nxt_in_bounds = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x    <= '0;
            cur_y    <= '0;
            row_base <= '0;
            x_start  <= '0;
            x_end    <= '0;
            y_end    <= '0;
        end else begin
            cur_x    <= nxt_x;
            cur_y    <= nxt_y;
            row_base <= nxt_row;
            if (load) begin
                x_start <= {1'b0, x0};
                x_end   <= {1'b0, x0} + {1'b0, w};
                y_end   <= {1'b0, y0} + {1'b0, h};
            end
        end
    end

endmodule

// File: rtl/gmem_fill_engine.sv
// Bus-mapped gmem drawing engine: single-pixel writes and rectangle fills.
// Optional GMEM_FILL_CLIP_EN suppresses writes outside the framebuffer.
module gmem_fill_engine
    import gmem_pkg::*;
#(
    parameter int unsigned FB_W = 160,
    parameter int unsigned FB_H = 120
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        bus_en_i,
    input  logic        bus_we_i,
    input  logic [2:0]  bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_ready_o,
    output logic        gmemEn_o,
    output logic        gmemWEn_o,
    output logic [14:0] gmemAddr_o,
    output logic [15:0] gmemWData_o,
    output logic        done_o
);

    fill_state_t state_q, state_nxt;
    logic [7:0]  rect_x0, rect_y0, rect_w, rect_h;
    rgb565_t     color_q, fill_color;
    logic        done_q, ready_q;
    logic [31:0] rdata_q, rdata_nxt;
    logic        wr_en_q, wr_en_nxt;
    logic [14:0] wr_addr_q, wr_addr_nxt;
    rgb565_t     wr_data_q, wr_data_nxt;

    logic        busy, wr_acc, rd_acc, ctrl_wr, start_req, size_zero, start_go, pix_wr;
    logic        step, fill_end, pix_in;
    logic [7:0]  pix_x, pix_y;
    logic [14:0] walk_addr;
    logic        walk_in, walk_last;

    assign busy      = (state_q == ST_FILL);
    assign wr_acc    = bus_en_i & bus_we_i & ready_q;
    assign rd_acc    = bus_en_i & ~bus_we_i;
    assign ctrl_wr   = wr_acc && (bus_addr_i == REG_CTRL);
    assign start_req = ctrl_wr && bus_wdata_i[CTRL_START_BIT];
    assign size_zero = (rect_w == '0) || (rect_h == '0);
    assign start_go  = start_req && !size_zero && !busy;
    assign pix_wr    = wr_acc && (bus_addr_i == REG_PIXEL);
    assign pix_x     = bus_wdata_i[23:16];
    assign pix_y     = bus_wdata_i[31:24];

`ifdef GMEM_FILL_CLIP_EN
    assign pix_in = (32'(pix_x) < FB_W) && (32'(pix_y) < FB_H);
`else
    assign pix_in = 1'b1;
`endif

    gmem_raster_walker #(.FB_W(FB_W), .FB_H(FB_H)) u_walker (
        .clk           (sys_clk_i),
        .rst_n         (rst_i),
        .load          (start_go),
        .step          (step),
        .x0            (rect_x0),
        .y0            (rect_y0),
        .w             (rect_w),
        .h             (rect_h),
        .nxt_addr      (walk_addr),
        .nxt_in_bounds (walk_in),
        .last          (walk_last)
    );

    always_comb begin
        state_nxt = state_q;
        step      = 1'b0;
        fill_end  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_go) state_nxt = ST_FILL;
            ST_FILL: begin
                if (walk_last) begin
                    state_nxt = ST_IDLE;
                    fill_end  = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The first fill pixel is registered on the accepting edge itself.
    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        if (start_go || step) begin
            wr_en_nxt   = walk_in;
            wr_addr_nxt = walk_addr;
            wr_data_nxt = start_go ? color_q : fill_color;
        end else if (pix_wr) begin
            wr_en_nxt   = pix_in;
            wr_addr_nxt = lin_addr({1'b0, pix_y}, {1'b0, pix_x}, FB_W);
            wr_data_nxt = bus_wdata_i[15:0];
        end
    end

    always_comb begin
        rdata_nxt = '0;
        case (bus_addr_i)
            REG_STATUS: begin
                rdata_nxt[STAT_DONE_BIT] = done_q;
                rdata_nxt[STAT_BUSY_BIT] = busy;
            end
            REG_RECT_POS:  rdata_nxt[15:0] = {rect_y0, rect_x0};
            REG_RECT_SIZE: rdata_nxt[15:0] = {rect_h, rect_w};
            REG_COLOR:     rdata_nxt[15:0] = color_q;
            default:       rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge sys_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rect_x0    <= '0;
            rect_y0    <= '0;
            rect_w     <= '0;
            rect_h     <= '0;
            color_q    <= '0;
            fill_color <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ready_q   <= (state_nxt == ST_IDLE);
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
            if (rd_acc) rdata_q <= rdata_nxt;
            if (wr_acc) begin
                case (bus_addr_i)
                    REG_RECT_POS:  {rect_y0, rect_x0} <= bus_wdata_i[15:0];
                    REG_RECT_SIZE: {rect_h, rect_w}   <= bus_wdata_i[15:0];
                    REG_COLOR:     color_q            <= bus_wdata_i[15:0];
                    default: ;
                endcase
            end
            if (start_go) fill_color <= color_q;
            // Clear before start: a zero-size start re-sets done after the clear.
            if (fill_end) begin
                done_q <= 1'b1;
            end else if (ctrl_wr) begin
                if (bus_wdata_i[CTRL_CLEAR_BIT]) done_q <= 1'b0;
                if (start_req && size_zero)      done_q <= 1'b1;
            end
        end
    end

    assign bus_rdata_o = rdata_q;
    assign bus_ready_o = ready_q;
    assign gmemEn_o    = wr_en_q;
    assign gmemWEn_o   = wr_en_q;
    assign gmemAddr_o  = wr_addr_q;
    assign gmemWData_o = wr_data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_gmem_fill_engine.sv
// Self-checking bench for gmem_fill_engine against a loop-based raster model.
// Honours GMEM_FILL_CLIP_EN when building expectations.
module tb_gmem_fill_engine;

    localparam int FB_W = 160;
    localparam int FB_H = 120;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_en = 1'b0;
    logic        bus_we = 1'b0;
    logic [2:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata_o;
    logic        bus_ready_o, gmemEn_o, gmemWEn_o, done_o;
    logic [14:0] gmemAddr_o;
    logic [15:0] gmemWData_o;

    gmem_fill_engine #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .sys_clk_i   (clk),
        .rst_i       (rst_n),
        .bus_en_i    (bus_en),
        .bus_we_i    (bus_we),
        .bus_addr_i  (bus_addr),
        .bus_wdata_i (bus_wdata),
        .bus_rdata_o (bus_rdata_o),
        .bus_ready_o (bus_ready_o),
        .gmemEn_o    (gmemEn_o),
        .gmemWEn_o   (gmemWEn_o),
        .gmemAddr_o  (gmemAddr_o),
        .gmemWData_o (gmemWData_o),
        .done_o      (done_o)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   we_mismatch = 0;
    int   done_rise = -1;
    logic done_prev = 1'b0;
    wr_t  wq[$];
    wr_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gmemEn_o || gmemWEn_o) begin
            if (gmemEn_o !== gmemWEn_o) we_mismatch++;
            wq.push_back('{cyc, int'(gmemAddr_o), int'(gmemWData_o)});
        end
        if (done_o && !done_prev && done_rise < 0) done_rise = cyc;
        done_prev = done_o;
    end

    function automatic bit in_view(int x, int y);
`ifdef GMEM_FILL_CLIP_EN
        return (x < FB_W) && (y < FB_H);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int ref_addr(int x, int y);
        return (y * FB_W + x) % 32768;
    endfunction

    // Expected writes of a fill accepted at cycle n: pixel k lands at n+1+k.
    task automatic build_fill(input int n, input int x0, input int y0, input int w,
                              input int h, input int color);
        exp_q.delete();
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                if (in_view(x0 + i, y0 + j))
                    exp_q.push_back('{n + 1 + j * w + i, ref_addr(x0 + i, y0 + j), color});
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int acc);
        int n = 0;
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        while (bus_ready_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL bus_write_timeout: ready=%b required 1", bus_ready_o);
        end
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_en = 1'b0;
        d = bus_rdata_o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rect(input int x0, input int y0, input int w, input int h, input int color);
        int n;
        bus_write(3'd2, {16'h0, 8'(y0), 8'(x0)}, n);
        bus_write(3'd3, {16'h0, 8'(h), 8'(w)}, n);
        bus_write(3'd4, {16'h0, 16'(color)}, n);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        @(negedge clk);
        tests++;
        if ({bus_rdata_o, bus_ready_o, gmemEn_o, gmemWEn_o, gmemAddr_o, gmemWData_o, done_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdata=%h ready=%b en=%b we=%b addr=%0d data=%h done=%b required all 0",
                     bus_rdata_o, bus_ready_o, gmemEn_o, gmemWEn_o, gmemAddr_o, gmemWData_o, done_o);
        end
        rst_n = 1'b1;
        tests++;
        if (bus_ready_o !== 1'b0) begin
            fails++; $display("FAIL ready_at_release: got %b required 0", bus_ready_o);
        end
        @(negedge clk);
        tests++;
        if (bus_ready_o !== 1'b1) begin
            fails++; $display("FAIL ready_after_first_clock: got %b required 1", bus_ready_o);
        end
        bus_read(3'd1, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++; $display("FAIL status_after_reset: got %h required 0", rd);
        end
    endtask

    task automatic test_pixel;
        int n, x, y, c;
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                x = 3; y = 2; c = 'hF800;
            end else begin
                x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255));
                c = int'($urandom_range(1, 65535));
            end
            wq.delete();
            bus_write(3'd5, {8'(y), 8'(x), 16'(c)}, n);
            idle(3);
            tests++;
            if (in_view(x, y)) begin
                if (wq.size() != 1 || wq[0].cyc != n + 1 || wq[0].addr != ref_addr(x, y) || wq[0].data != c) begin
                    fails++;
                    $display("FAIL pixel_write x=%0d y=%0d: got %0d writes first cyc=%0d addr=%0d data=%h required 1 write cyc=%0d addr=%0d data=%h",
                             x, y, wq.size(), (wq.size() > 0) ? wq[0].cyc : -1, (wq.size() > 0) ? wq[0].addr : -1,
                             (wq.size() > 0) ? wq[0].data : -1, n + 1, ref_addr(x, y), c);
                end
            end else if (wq.size() != 0) begin
                fails++;
                $display("FAIL pixel_clipped x=%0d y=%0d: got %0d writes required 0", x, y, wq.size());
            end
        end
        tests++;
        if (ref_addr(3, 2) != 323) begin
            fails++; $display("FAIL pixel_ref_addr: got %0d required 323", ref_addr(3, 2));
        end
    endtask

    task automatic test_fill_directed;
        int n, np;
        logic [31:0] rd;
        set_rect(10, 5, 4, 3, 'h07E0);
        wq.delete();
        done_rise = -1;
        bus_write(3'd0, 32'h3, n);
        bus_read(3'd1, rd);
        tests++;
        if (rd !== 32'h1) begin
            fails++; $display("FAIL status_during_fill: got %h required 1", rd);
        end
        bus_write(3'd5, {8'd7, 8'd9, 16'h1234}, np);
        idle(4);
        build_fill(n, 10, 5, 4, 3, 'h07E0);
        exp_q.push_back('{n + 14, 1129, 'h1234});
        tests++;
        if (np != n + 13) begin
            fails++; $display("FAIL pixel_stall: accepted at %0d required %0d", np, n + 13);
        end
        tests++;
        if (wq.size() != exp_q.size()) begin
            fails++; $display("FAIL fill_directed_count: got %0d required %0d", wq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wq.size(); i++) begin
                tests++;
                if (wq[i].cyc != exp_q[i].cyc || wq[i].addr != exp_q[i].addr || wq[i].data != exp_q[i].data) begin
                    fails++;
                    $display("FAIL fill_directed[%0d]: got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                             i, wq[i].cyc, wq[i].addr, wq[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                end
            end
            tests++;
            if (wq[0].addr != 810 || wq[4].addr != 970 || wq[11].addr != 1133) begin
                fails++;
                $display("FAIL fill_directed_rows: got %0d/%0d/%0d required 810/970/1133",
                         wq[0].addr, wq[4].addr, wq[11].addr);
            end
        end
        tests++;
        if (done_rise != n + 13) begin
            fails++; $display("FAIL fill_done_cycle: got %0d required %0d", done_rise, n + 13);
        end
    endtask

    task automatic test_random_fill;
        int n, x0, y0, w, h, c;
        logic [31:0] rd;
        for (int t = 0; t < 6; t++) begin
            x0 = int'($urandom_range(0, 255)); y0 = int'($urandom_range(0, 255));
            w = int'($urandom_range(1, 8));    h = int'($urandom_range(1, 6));
            c = int'($urandom_range(0, 65535));
            set_rect(x0, y0, w, h, c);
            wq.delete();
            done_rise = -1;
            bus_write(3'd0, 32'h3, n);
            idle(w * h + 4);
            build_fill(n, x0, y0, w, h, c);
            tests++;
            if (wq.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand_fill_count x0=%0d y0=%0d w=%0d h=%0d: got %0d required %0d",
                         x0, y0, w, h, wq.size(), exp_q.size());
            end else begin
                for (int i = 0; i < wq.size(); i++) begin
                    tests++;
                    if (wq[i].cyc != exp_q[i].cyc || wq[i].addr != exp_q[i].addr || wq[i].data != exp_q[i].data) begin
                        fails++;
                        $display("FAIL rand_fill[%0d] x0=%0d y0=%0d: got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                                 i, x0, y0, wq[i].cyc, wq[i].addr, wq[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    end
                end
            end
            tests++;
            if (done_rise != n + w * h + 1) begin
                fails++; $display("FAIL rand_fill_done: got %0d required %0d", done_rise, n + w * h + 1);
            end
            bus_read(3'd1, rd);
            tests++;
            if (rd !== 32'h2) begin
                fails++; $display("FAIL rand_fill_status: got %h required 2", rd);
            end
        end
    endtask

    task automatic test_zero_size;
        int n;
        logic [31:0] rd;
        bus_write(3'd0, 32'h2, n);
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_rect(7, 7, 0, 3, 'hABCD);
            else        set_rect(7, 7, 5, 0, 'hABCD);
            wq.delete();
            done_rise = -1;
            bus_write(3'd0, (t == 0) ? 32'h3 : 32'h1, n);
            idle(6);
            tests++;
            if (wq.size() != 0) begin
                fails++; $display("FAIL zero_size_writes: got %0d required 0", wq.size());
            end
            tests++;
            if (done_rise != n + 1) begin
                fails++; $display("FAIL zero_size_done: got %0d required %0d", done_rise, n + 1);
            end
            bus_read(3'd1, rd);
            tests++;
            if (rd !== 32'h2) begin
                fails++; $display("FAIL zero_size_status: got %h required 2", rd);
            end
            bus_write(3'd0, 32'h2, n);
            bus_read(3'd1, rd);
            tests++;
            if (rd !== 32'h0 || done_o !== 1'b0) begin
                fails++; $display("FAIL done_clear: status=%h done=%b required 0/0", rd, done_o);
            end
        end
        bus_read(3'd3, rd);
        tests++;
        if (rd !== 32'h0005) begin
            fails++; $display("FAIL rect_size_readback: got %h required 00000005", rd);
        end
    endtask

    task automatic test_clip_edge;
        int n;
        set_rect(158, 0, 4, 1, 'h001F);
        wq.delete();
        done_rise = -1;
        bus_write(3'd0, 32'h3, n);
        idle(8);
        exp_q.delete();
        exp_q.push_back('{n + 1, 158, 'h001F});
        exp_q.push_back('{n + 2, 159, 'h001F});
`ifndef GMEM_FILL_CLIP_EN
        exp_q.push_back('{n + 3, 160, 'h001F});
        exp_q.push_back('{n + 4, 161, 'h001F});
`endif
        tests++;
        if (wq.size() != exp_q.size()) begin
            fails++; $display("FAIL edge_count: got %0d required %0d", wq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wq.size(); i++) begin
                tests++;
                if (wq[i].cyc != exp_q[i].cyc || wq[i].addr != exp_q[i].addr) begin
                    fails++;
                    $display("FAIL edge[%0d]: got cyc=%0d addr=%0d required cyc=%0d addr=%0d",
                             i, wq[i].cyc, wq[i].addr, exp_q[i].cyc, exp_q[i].addr);
                end
            end
        end
        tests++;
        if (done_rise != n + 5) begin
            fails++; $display("FAIL edge_done: got %0d required %0d", done_rise, n + 5);
        end
    endtask

    task automatic test_reset_midfill;
        int n;
        logic [31:0] rd;
        set_rect(20, 30, 10, 10, 'h5555);
        bus_write(3'd0, 32'h3, n);
        idle(2);
        tests++;
        if (gmemEn_o !== 1'b1 || gmemAddr_o !== 15'd4822) begin
            fails++; $display("FAIL midfill_third_pixel: en=%b addr=%0d required 1/4822", gmemEn_o, gmemAddr_o);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus_rdata_o, bus_ready_o, gmemEn_o, gmemWEn_o, gmemAddr_o, gmemWData_o, done_o} !== '0) begin
            fails++;
            $display("FAIL midfill_reset_outputs: ready=%b en=%b we=%b addr=%0d data=%h done=%b required all 0",
                     bus_ready_o, gmemEn_o, gmemWEn_o, gmemAddr_o, gmemWData_o, done_o);
        end
        idle(2);
        wq.delete();
        rst_n = 1'b1;
        idle(150);
        tests++;
        if (wq.size() != 0) begin
            fails++; $display("FAIL midfill_writes_after_release: got %0d required 0", wq.size());
        end
        bus_read(3'd1, rd);
        tests++;
        if (rd !== 32'h0 || done_o !== 1'b0) begin
            fails++; $display("FAIL midfill_status: status=%h done=%b required 0/0", rd, done_o);
        end
    endtask

    initial begin
        test_reset;
        test_pixel;
        test_fill_directed;
        test_random_fill;
        test_zero_size;
        test_clip_edge;
        test_reset_midfill;
        tests++;
        if (we_mismatch != 0) begin
            fails++; $display("FAIL en_we_match: got %0d mismatched cycles required 0", we_mismatch);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
